// File: rtl/harmonic_pos_sequencer_pkg.sv
// Shared constants for the harmonic phase-position sequencer and its position RAM.
// State codes include CLEAR, which is used only when CLEAR_ON_RESET_EN is defined.
package harmonic_pos_sequencer_pkg;

    localparam int ADDR_WIDTH_DEF = 8;
    localparam int DATA_WIDTH_DEF = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_READ  = 3'd1;
    localparam state_t ST_WRITE = 3'd2;
    localparam state_t ST_DONE  = 3'd3;
    localparam state_t ST_CLEAR = 3'd4;

endpackage

// File: rtl/harmonic_pos_sequencer.sv
// Per-frame phase accumulator sweep over N harmonics stored in an external position RAM.
// Optional feature: define CLEAR_ON_RESET_EN to zero the whole RAM after every reset.
module harmonic_pos_sequencer
    import harmonic_pos_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_start,
    input  logic [DATA_WIDTH-1:0] freq,
    input  logic [ADDR_WIDTH-1:0] harm_count,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] pos_out,
    output logic [ADDR_WIDTH-1:0] pos_index,
    output logic                  pos_valid,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun
);

`ifdef CLEAR_ON_RESET_EN
    localparam state_t RESET_STATE = ST_CLEAR;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    localparam logic [DATA_WIDTH:0] NYQUIST = (DATA_WIDTH+1)'(1) << (DATA_WIDTH-1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                state;
    logic [ADDR_WIDTH-1:0] h;
    logic [DATA_WIDTH-1:0] inc_acc;
    logic [DATA_WIDTH-1:0] freq_reg;
    logic [ADDR_WIDTH-1:0] count_reg;
    logic [DATA_WIDTH-1:0] pos_reg;

    logic [DATA_WIDTH:0]   inc_next;
    logic [ADDR_WIDTH:0]   h_next;
    logic                  last_harm;

    // The carry bit keeps the Nyquist test exact even when freq is large.
    assign inc_next  = {1'b0, inc_acc} + {1'b0, freq_reg};
    assign h_next    = {1'b0, h} + 1'b1;
    assign last_harm = (h_next == {1'b0, count_reg});

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RESET_STATE;
            h         <= '0;
            inc_acc   <= '0;
            freq_reg  <= '0;
            count_reg <= '0;
            pos_reg   <= '0;
            overrun   <= 1'b0;
        end else begin
            if (sample_start && state != ST_IDLE)
                overrun <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (sample_start) begin
                        freq_reg  <= freq;
                        count_reg <= harm_count;
                        h         <= '0;
                        inc_acc   <= freq;
                        state     <= ST_READ;
                    end
                end
                ST_READ: begin
                    pos_reg <= ram_dout;
                    state   <= (count_reg == '0) ? ST_DONE : ST_WRITE;
                end
                ST_WRITE: begin
                    if (last_harm || inc_next >= NYQUIST) begin
                        state <= ST_DONE;
                    end else begin
                        h       <= h_next[ADDR_WIDTH-1:0];
                        inc_acc <= inc_next[DATA_WIDTH-1:0];
                        state   <= ST_READ;
                    end
                end
                ST_DONE: state <= ST_IDLE;
`ifdef CLEAR_ON_RESET_EN
                ST_CLEAR: begin
                    if (h == LAST_ADDR) begin
                        h     <= '0;
                        state <= ST_IDLE;
                    end else begin
                        h <= h + 1'b1;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        ram_addr   = h;
        ram_din    = '0;
        ram_we     = 1'b0;
        pos_out    = '0;
        pos_index  = '0;
        pos_valid  = 1'b0;
        busy       = (state != ST_IDLE);
        frame_done = (state == ST_DONE);
        if (state == ST_WRITE) begin
            ram_we    = 1'b1;
            ram_din   = pos_reg + inc_acc;
            pos_out   = pos_reg;
            pos_index = h;
            pos_valid = 1'b1;
        end else if (state == ST_CLEAR) begin
            ram_we = 1'b1;
        end
    end

endmodule

// File: tb/tb_harmonic_pos_sequencer.sv
// Self-checking bench for harmonic_pos_sequencer with a behavioural RAM and frame model.
// Follows CLEAR_ON_RESET_EN the same way the design does.
module tb_harmonic_pos_sequencer;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          sample_start;
    logic [DW-1:0] freq;
    logic [AW-1:0] harm_count;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout;
    logic [DW-1:0] pos_out;
    logic [AW-1:0] pos_index;
    logic          pos_valid;
    logic          busy;
    logic          frame_done;
    logic          overrun;

    logic          preload;
    logic [DW-1:0] preload_val;
    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    int checks   = 0;
    int failures = 0;

    int q_addr[$];
    int q_din[$];
    int q_pos[$];

    harmonic_pos_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .sample_start(sample_start), .freq(freq),
        .harm_count(harm_count), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_we(ram_we), .ram_dout(ram_dout), .pos_out(pos_out),
        .pos_index(pos_index), .pos_valid(pos_valid), .busy(busy),
        .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    assign ram_dout = mem[ram_addr];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= preload_val;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected writes of one frame: harmonic h gets freq*(h+1); stop at harm_count or when the
    // following harmonic's increment would reach half the phase range.
    function automatic void plan(input int f, input int hc);
        q_addr.delete(); q_din.delete(); q_pos.delete();
        for (int h = 0; h < hc; h++) begin
            int inc;
            inc = (f * (h + 1)) % (1 << DW);
            q_addr.push_back(h);
            q_pos.push_back(int'(ref_mem[h]));
            q_din.push_back((int'(ref_mem[h]) + inc) % (1 << DW));
            if (f * (h + 2) >= (1 << (DW - 1))) break;
        end
    endfunction

    task automatic observe_write(input string tag);
        if (ram_we) begin
            if (q_addr.size() == 0) begin
                check({tag, "_extra_write"}, 32'(ram_addr), 32'hFFFF_FFFF);
            end else begin
                check({tag, "_addr"}, 32'(ram_addr), 32'(q_addr[0]));
                check({tag, "_din"}, 32'(ram_din), 32'(q_din[0]));
                check({tag, "_pos_out"}, 32'(pos_out), 32'(q_pos[0]));
                check({tag, "_pos_index"}, 32'(pos_index), 32'(q_addr[0]));
                ref_mem[q_addr[0]] = DW'(q_din[0]);
                void'(q_addr.pop_front()); void'(q_din.pop_front()); void'(q_pos.pop_front());
            end
        end
        check({tag, "_valid_eq_we"}, 32'(pos_valid), 32'(ram_we));
    endtask

    // Caller sits at a negedge; reset is sampled at the next posedge.
    task automatic do_reset(input bit pre, input logic [DW-1:0] pval);
        reset = 1'b1; sample_start = 1'b0; preload = pre; preload_val = pval;
        @(negedge clk);
        reset = 1'b0; preload = 1'b0;
        if (pre) for (int i = 0; i < DEPTH; i++) ref_mem[i] = pval;
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_pos_valid", 32'(pos_valid), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_ram_din", 32'(ram_din), 0);
        check("rst_pos_out", 32'(pos_out), 0);
        check("rst_pos_index", 32'(pos_index), 0);
`ifdef CLEAR_ON_RESET_EN
        begin
            int n = 0;
            int bad = 0;
            check("rst_busy", 32'(busy), 1);
            check("rst_ram_we", 32'(ram_we), 1);
            for (int cyc = 0; cyc < DEPTH + 20; cyc++) begin
                if (!busy) break;
                if (ram_we && ram_din == '0 && 32'(ram_addr) == 32'(n % DEPTH)) n++;
                else bad++;
                @(negedge clk);
            end
            check("clear_write_count", 32'(n), 32'(DEPTH));
            check("clear_bad_cycles", 32'(bad), 0);
            check("clear_then_idle", 32'(busy), 0);
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end
`else
        check("rst_busy", 32'(busy), 0);
        check("rst_ram_we", 32'(ram_we), 0);
`endif
    endtask

    task automatic run_frame(input logic [DW-1:0] f, input logic [AW-1:0] hc, input bit second_start);
        int n_exp;
        int lat;
        int writes = 0;
        bit done = 1'b0;
        plan(int'(f), int'(hc));
        n_exp = q_addr.size();
        lat = (n_exp == 0) ? 2 : 2 * n_exp + 1;
        @(negedge clk);
        freq = f; harm_count = hc; sample_start = 1'b1;
        for (int cyc = 1; cyc <= lat + 4 && !done; cyc++) begin
            @(negedge clk);
            sample_start = (cyc == 1) ? second_start : 1'b0;
            if (ram_we) writes++;
            observe_write("frame");
            check("frame_busy", 32'(busy), 1);
            if (frame_done) begin
                done = 1'b1;
                check("frame_done_latency", 32'(cyc), 32'(lat));
            end
        end
        if (!done) check("frame_done_timeout", 0, 1);
        check("frame_write_count", 32'(writes), 32'(n_exp));
        @(negedge clk);
        check("frame_idle_busy", 32'(busy), 0);
        check("frame_idle_done", 32'(frame_done), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; sample_start = 1'b0; freq = '0; harm_count = '0;
        preload = 1'b0; preload_val = '0;
        @(negedge clk);
`ifdef CLEAR_ON_RESET_EN
        do_reset(1'b1, 16'hFFFF);
`else
        do_reset(1'b1, 16'h0000);
`endif

        run_frame(16'h0100, 8'd3, 1'b0);
        check("first_frame_mem2", 32'(mem[2]), 32'h0300);
        run_frame(16'h0100, 8'd3, 1'b0);
        check("second_frame_mem0", 32'(mem[0]), 32'h0200);
        check("second_frame_mem1", 32'(mem[1]), 32'h0400);
        check("second_frame_mem2", 32'(mem[2]), 32'h0600);

        run_frame(16'h3000, 8'd8, 1'b0);
        check("nyquist_mem2_untouched", 32'(mem[2]), 32'h0600);

        check("overrun_before", 32'(overrun), 0);
        run_frame(16'h0040, 8'd0, 1'b1);
        check("overrun_after", 32'(overrun), 1);

        for (int k = 0; k < 12; k++) begin
            logic [DW-1:0] f;
            logic [AW-1:0] hc;
            f  = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 16'h0900));
            hc = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 40));
            run_frame(f, hc, 1'($urandom_range(0, 1)));
        end

        // Reset landing on the WRITE of harmonic 5 out of 10.
        begin
            bit hit = 1'b0;
            plan(16'h0010, 10);
            @(negedge clk);
            freq = 16'h0010; harm_count = 8'd10; sample_start = 1'b1;
            for (int cyc = 1; cyc <= 40 && !hit; cyc++) begin
                @(negedge clk);
                sample_start = 1'b0;
                if (ram_we && ram_addr == 8'd5) hit = 1'b1;
                observe_write("midreset");
            end
            check("midreset_reached_h5", 32'(hit), 1);
            do_reset(1'b0, '0);
`ifndef CLEAR_ON_RESET_EN
            begin
                int stray = 0;
                for (int cyc = 0; cyc < 6; cyc++) begin
                    if (ram_we) stray++;
                    @(negedge clk);
                end
                check("midreset_no_writes", 32'(stray), 0);
                check("midreset_mem6_untouched", 32'(mem[6]), 32'(ref_mem[6]));
            end
`endif
        end
        run_frame(16'h0123, 8'd6, 1'b0);

        begin
            int mism = 0;
            for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) mism++;
            check("ram_image_mismatches", 32'(mism), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
